ct_ifu_icache_predecd_refill: RTL and testbench
===============================================

Name: ct_ifu_icache_predecd_refill

Overview:
- Refill-side predecode write sequencer, directly upstream of the icache predecode array.
- Takes 128-bit L2 refill beats for one 64-byte line and computes 4 predecode bits per halfword, giving 32 bits per beat.
- Issues one array write per beat, using the array's cen_b, wen_b, clk_en, index and din.
- Arbitrates for the array with fetch reads through a req/grant pair.
- Pulses done when all beats are written.

Parameters:
- INDEX_W, 16: width of the array index bus.
- BEATS, 4: refill beats per line; must be a power of 2.

Ports:
- forever_cpuclk  input  1  core clock
- cpurst_b  input  1  asynchronous active-low reset
- refill_start  input  1  start pulse for a new line refill
- refill_line_idx  input  10  line index, becomes index[15:6]
- refill_beat_vld  input  1  refill beat valid
- refill_beat_data  input  128  beat data, 8 halfwords
- refill_beat_rdy  output  1  beat accept ready
- refill_inv  input  1  icache invalidate/flush; aborts the refill
- predecd_arb_req  output  1  array write request
- predecd_arb_grant  input  1  array granted this cycle
- ifu_icache_predecd_array1_cen_b  output  1  chip enable, active low
- ifu_icache_predecd_array1_wen_b  output  1  write enable, active low
- ifu_icache_predecd_array1_clk_en  output  1  local ICG enable
- ifu_icache_index  output  INDEX_W  array index
- ifu_icache_predecd_array1_din  output  32  predecode write data
- refill_predecd_done  output  1  one-cycle completion pulse

Behaviour:
- Clocking and reset: single clock forever_cpuclk; async active-low reset cpurst_b.
- Reset values: state=IDLE, cnt=0, buffer=0, index=0, din=0; cen_b=1, wen_b=1; clk_en=0, rdy=0, req=0, done=0.
- Predecode of halfword h, for i=0..7, h=data[16i+15:16i]:
  - p[4i+0] = (h[1:0]==2'b11), i.e. 32-bit start.
  - p[4i+1] = p[4i+0] & (h[6:0]==7'b1100011), branch.
  - p[4i+2] = (p[4i+0] & h[6:0]==7'b1101111) | (h[1:0]==2'b01 & h[15:13]==3'b101), jal / c.j.
  - p[4i+3] = (p[4i+0] & h[6:0]==7'b1100111) | (h[1:0]==2'b10 & h[15:13]==3'b100 & h[6:2]==0 & h[11:7]!=0), jalr / c.jr / c.jalr.
  - Each halfword is decoded independently; there is no cross-halfword state.
- FSM states: IDLE, WAIT_BEAT, REQ, DONE.
  - IDLE: refill_start latches line_idx and clears cnt, then goes to WAIT_BEAT.
  - WAIT_BEAT: rdy=1. On vld&rdy, register predecode(data) into buffer, then go to REQ.
  - REQ: req=1 and clk_en=1. Array strobes are combinational: cen_b=wen_b=~grant. The write occurs in the grant cycle. After grant, if cnt==BEATS-1 go to DONE, else cnt++ and go to WAIT_BEAT. Without grant, stay in REQ holding din and index.
  - DONE: done=1 for one cycle, then go to IDLE.
- Index and data: index = {line_idx, cnt[1:0], 4'b0000}; din = buffer. Both are registered and stable throughout REQ.
- Latency: beat accept to earliest write is 1 cycle. Minimum line time is 2*BEATS+1 cycles from refill_start to the done pulse.
- Boundaries:
  - refill_start outside IDLE is ignored.
  - vld while not in WAIT_BEAT is not accepted (rdy=0).
  - refill_inv in any state goes to IDLE next cycle, no done pulse, and cen_b is forced to 1 in that same cycle, even if grant is present. inv has priority over start in the same cycle.
  - Reset mid-line aborts with no partial write continued.
  - cnt wraps only via the DONE→IDLE path.

Optional Feature:
- Macro ICACHE_PREDECD_BYPASS_EN.
- When defined, two extra outputs are added:
  - predecd_bypass_vld (1 bit): asserted in the cycle a beat is accepted.
  - predecd_bypass_data (32 bits): combinational predecode of refill_beat_data, so fetch can use refilling-line predecode with zero delay.
- When undefined, the ports are absent and there is no extra logic.

Decomposition:
- Shared package: FSM state encodings, RISC-V opcode constants (BRANCH, JAL, JALR) and compressed funct3 constants, BEATS, and the line/beat index field widths.
- One natural sub-module, ct_ifu_predecd_hw: purely combinational 16-bit halfword to 4-bit predecode decoder. It is instantiated 8 times here and is reused for the bypass path.

Test Plan:
- Full line, grant always 1: start with line_idx=10'h155, then 4 beats back-to-back. Expect 4 writes at index 16'h5540/5550/5560/5570, and done 9 cycles after start.
- Predecode values:
  - Beat halfwords 0x0063,0x0000 (branch) → din nibble0 = 4'b0011.
  - Halfword 0xA001 (c.j) → 4'b0100.
  - Halfword 0x8082 (c.jr ra) → 4'b1000.
  - Halfword 0x006F (jal) → 4'b0101.
- Grant withheld 3 cycles in REQ: cen_b/wen_b held 1, index/din stable, rdy=0. Write on the 4th cycle, then the next beat is accepted.
- refill_inv asserted in REQ with grant=1 on beat 2: no write that cycle (cen_b=1), FSM returns to IDLE, done never pulses, and the next start works normally.
- Reset asserted mid-line (after beat 1): all outputs return to reset values immediately; after release, rdy=0 until a new start.
- With ICACHE_PREDECD_BYPASS_EN: predecd_bypass_data equals din of the subsequent write, and bypass_vld coincides with vld&rdy.

Source files
------------

// File: rtl/ct_ifu_icache_predecd_refill_pkg.sv
// ct_ifu_icache_predecd_refill_pkg: shared state encoding, RISC-V opcode constants and refill geometry
package ct_ifu_icache_predecd_refill_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BEAT, REQ, DONE} state_e;
  localparam int PD_BEATS = 4;
  localparam int LINE_W = 10;
  localparam int OFF_W = 4;
  localparam logic [1:0] RVI = 2'b11;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [2:0] C_J_F3 = 3'b101;
  localparam logic [2:0] C_JR_F3 = 3'b100;
endpackage

// File: rtl/ct_ifu_predecd_hw.sv
// ct_ifu_predecd_hw: halfword to {jalr, jal, branch, 32-bit start} predecode bits
module ct_ifu_predecd_hw
  import ct_ifu_icache_predecd_refill_pkg::*;
(
  input  logic [15:0] hw,
  output logic [3:0]  pd
);
  logic rvi;
  always_comb begin
    rvi   = hw[1:0] == RVI;
    pd[0] = rvi;
    pd[1] = rvi && hw[6:0] == OP_BRANCH;
    pd[2] = (rvi && hw[6:0] == OP_JAL) || (hw[1:0] == RVC_Q1 && hw[15:13] == C_J_F3);
    pd[3] = (rvi && hw[6:0] == OP_JALR) ||
            (hw[1:0] == RVC_Q2 && hw[15:13] == C_JR_F3 && hw[6:2] == 5'd0 && hw[11:7] != 5'd0);
  end
endmodule

// File: rtl/ct_ifu_icache_predecd_refill.sv
// ct_ifu_icache_predecd_refill: refill predecode write sequencer; ICACHE_PREDECD_BYPASS_EN adds a zero-delay bypass port
module ct_ifu_icache_predecd_refill
  import ct_ifu_icache_predecd_refill_pkg::*;
#(
  parameter int INDEX_W = 16,
  parameter int BEATS   = PD_BEATS
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 refill_start,
  input  logic [LINE_W-1:0]    refill_line_idx,
  input  logic                 refill_beat_vld,
  input  logic [127:0]         refill_beat_data,
  output logic                 refill_beat_rdy,
  input  logic                 refill_inv,
  output logic                 predecd_arb_req,
  input  logic                 predecd_arb_grant,
  output logic                 ifu_icache_predecd_array1_cen_b,
  output logic                 ifu_icache_predecd_array1_wen_b,
  output logic                 ifu_icache_predecd_array1_clk_en,
  output logic [INDEX_W-1:0]   ifu_icache_index,
  output logic [31:0]          ifu_icache_predecd_array1_din,
  output logic                 refill_predecd_done
`ifdef ICACHE_PREDECD_BYPASS_EN
  ,
  output logic                 predecd_bypass_vld,
  output logic [31:0]          predecd_bypass_data
`endif
);
  localparam int CNT_W = $clog2(BEATS);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         buf_q, buf_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic                rdy_q, rdy_d, req_q, req_d, clk_en_q, clk_en_d, done_q, done_d;
  logic [31:0]         pd_beat;
  logic                last, wr;
  for (genvar i = 0; i < 8; i++) begin : g_hw
    ct_ifu_predecd_hw u_hw (.hw(refill_beat_data[16*i+:16]), .pd(pd_beat[4*i+:4]));
  end
  assign last = cnt_q == CNT_W'(BEATS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (refill_start) begin
        state_d = WAIT_BEAT;
        cnt_d   = '0;
        line_d  = refill_line_idx;
      end
      WAIT_BEAT: if (refill_beat_vld) begin
        state_d = REQ;
        buf_d   = pd_beat;
        idx_d   = INDEX_W'({line_q, cnt_q, {OFF_W{1'b0}}});
      end
      REQ: if (predecd_arb_grant) begin
        state_d = last ? DONE : WAIT_BEAT;
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (refill_inv) state_d = IDLE;
    rdy_d    = state_d == WAIT_BEAT;
    req_d    = state_d == REQ;
    clk_en_d = state_d == REQ;
    done_d   = state_d == DONE;
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      buf_q    <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b0;
      req_q    <= 1'b0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
      req_q    <= req_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
    end
  end
  // an invalidate kills the strobe even when the grant lands in the same cycle
  assign wr = req_q && predecd_arb_grant && !refill_inv;
  assign ifu_icache_predecd_array1_cen_b  = !wr;
  assign ifu_icache_predecd_array1_wen_b  = !wr;
  assign ifu_icache_predecd_array1_clk_en = clk_en_q;
  assign ifu_icache_index                 = idx_q;
  assign ifu_icache_predecd_array1_din    = buf_q;
  assign refill_beat_rdy                  = rdy_q;
  assign predecd_arb_req                  = req_q;
  assign refill_predecd_done              = done_q;
`ifdef ICACHE_PREDECD_BYPASS_EN
  assign predecd_bypass_vld  = rdy_q && refill_beat_vld;
  assign predecd_bypass_data = pd_beat;
`endif
endmodule

// File: tb/tb_ct_ifu_icache_predecd_refill.sv
// tb_ct_ifu_icache_predecd_refill: scoreboard bench for the refill predecode write sequencer
module tb_ct_ifu_icache_predecd_refill;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, vld = 1'b0, inv = 1'b0, grant = 1'b1;
  logic [9:0] line = '0, line_cur = '0;
  logic [127:0] data = '0;
  logic rdy, req, cen_b, wen_b, clk_en, done;
  logic [15:0] idx;
  logic [31:0] din;
  typedef struct {logic [15:0] idx; logic [31:0] din;} wr_t;
  wr_t sb[$];
  wr_t e;
  logic [31:0] dlog[$];
  logic [15:0] ilog[$];
  int n_tests = 0, n_fail = 0, done_cnt = 0;
  int unsigned cyc = 0, cs = 0;
  logic [15:0] tbl[8] = '{16'h0063, 16'hA001, 16'h8082, 16'h006F, 16'h00E7, 16'h9002, 16'h80E7, 16'h0001};
`ifdef ICACHE_PREDECD_BYPASS_EN
  logic byp_vld;
  logic [31:0] byp_data;
`endif

  ct_ifu_icache_predecd_refill dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .refill_start(start), .refill_line_idx(line),
    .refill_beat_vld(vld), .refill_beat_data(data), .refill_beat_rdy(rdy), .refill_inv(inv),
    .predecd_arb_req(req), .predecd_arb_grant(grant),
    .ifu_icache_predecd_array1_cen_b(cen_b), .ifu_icache_predecd_array1_wen_b(wen_b),
    .ifu_icache_predecd_array1_clk_en(clk_en), .ifu_icache_index(idx),
    .ifu_icache_predecd_array1_din(din), .refill_predecd_done(done)
`ifdef ICACHE_PREDECD_BYPASS_EN
    , .predecd_bypass_vld(byp_vld), .predecd_bypass_data(byp_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pd_hw(input logic [15:0] h);
    logic s;
    s = h[1:0] == 2'b11;
    return {(s && h[6:2] == 5'b11001) || (h[1:0] == 2'b10 && h[15:13] == 3'b100 && h[6:2] == 5'd0 && h[11:7] != 5'd0),
            (s && h[6:2] == 5'b11011) || (h[1:0] == 2'b01 && h[15:13] == 3'b101),
            s && h[6:2] == 5'b11000, s};
  endfunction

  function automatic logic [31:0] pd_beat(input logic [127:0] d);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i+:4] = pd_hw(d[16*i+:16]);
    return r;
  endfunction

  function automatic logic [127:0] rand_beat();
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[16*i+:16] = $urandom_range(0, 1) ? tbl[$urandom_range(0, 7)] : 16'($urandom);
    return d;
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
`ifdef ICACHE_PREDECD_BYPASS_EN
    check("byp_vld", byp_vld, vld && rdy);
    if (vld && rdy) check("byp_data", byp_data, pd_beat(data));
`endif
    if (rst_n && !cen_b) begin
      if (sb.size() == 0) check("spurious_wr", cen_b, 1);
      else begin
        e = sb.pop_front();
        check("wr_idx", idx, e.idx);
        check("wr_din", din, e.din);
        check("wr_wen", wen_b, 0);
        check("wr_clk_en", clk_en, 1);
        dlog.push_back(din);
        ilog.push_back(idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] l);
    start = 1'b1;
    line = l;
    line_cur = l;
    cs = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [1:0] bi);
    int k;
    data = d;
    vld = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rdy) break;
    end
    if (k == 30) begin
      check("beat_timeout", rdy, 1);
      vld = 1'b0;
      return;
    end
    e.idx = {line_cur, bi, 4'b0000};
    e.din = pd_beat(d);
    sb.push_back(e);
    tick();
    vld = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 40) check("done_timeout", done, 1);
    else if (exp_lat > 0) check("done_lat", cyc - cs, exp_lat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("sb_drained", sb.size(), 0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, rdy, 0);
    check({tag, "_req"}, req, 0);
    check({tag, "_cen"}, cen_b, 1);
    check({tag, "_wen"}, wen_b, 1);
    check({tag, "_clk_en"}, clk_en, 0);
    check({tag, "_idx"}, idx, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int d0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    // valid while idle is never accepted
    vld = 1'b1;
    data = rand_beat();
    repeat (2) begin
      @(negedge clk);
      check("idle_rdy", rdy, 0);
    end
    tick();
    vld = 1'b0;
    // full line, back-to-back beats, grant always high
    dlog.delete();
    ilog.delete();
    do_start(10'h155);
    for (int b = 0; b < 4; b++) send_beat(rand_beat(), 2'(b));
    wait_done(9);
    check("l1_idx0", ilog[0], 16'h5540);
    check("l1_idx1", ilog[1], 16'h5550);
    check("l1_idx2", ilog[2], 16'h5560);
    check("l1_idx3", ilog[3], 16'h5570);
    // directed predecode halfwords
    dlog.delete();
    do_start(10'h2A3);
    d = rand_beat(); d[15:0] = 16'h0063; d[31:16] = 16'h0000; send_beat(d, 2'd0);
    d = rand_beat(); d[15:0] = 16'hA001; send_beat(d, 2'd1);
    d = rand_beat(); d[15:0] = 16'h8082; send_beat(d, 2'd2);
    d = rand_beat(); d[15:0] = 16'h006F; send_beat(d, 2'd3);
    wait_done(9);
    check("pd_branch", dlog[0][3:0], 4'b0011);
    check("pd_zero", dlog[0][7:4], 4'b0000);
    check("pd_cj", dlog[1][3:0], 4'b0100);
    check("pd_cjr", dlog[2][3:0], 4'b1000);
    check("pd_jal", dlog[3][3:0], 4'b0101);
    // grant withheld for three REQ cycles
    grant = 1'b0;
    do_start(10'h0F0);
    d = rand_beat();
    send_beat(d, 2'd0);
    repeat (3) begin
      @(negedge clk);
      check("hold_cen", cen_b, 1);
      check("hold_wen", wen_b, 1);
      check("hold_rdy", rdy, 0);
      check("hold_req", req, 1);
      check("hold_idx", idx, {10'h0F0, 6'h00});
      check("hold_din", din, pd_beat(d));
    end
    tick();
    grant = 1'b1;
    for (int b = 1; b < 4; b++) send_beat(rand_beat(), 2'(b));
    wait_done(0);
    // invalidate in REQ while granted on beat 2
    do_start(10'h3C7);
    send_beat(rand_beat(), 2'd0);
    send_beat(rand_beat(), 2'd1);
    send_beat(rand_beat(), 2'd2);
    d0 = done_cnt;
    inv = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("inv_cen", cen_b, 1);
    check("inv_wen", wen_b, 1);
    tick();
    inv = 1'b0;
    @(negedge clk);
    check("inv_rdy", rdy, 0);
    check("inv_req", req, 0);
    check("inv_clk_en", clk_en, 0);
    repeat (10) @(negedge clk);
    check("inv_no_done", done_cnt, d0);
    check("inv_sb", sb.size(), 0);
    tick();
    // new line after abort; a start mid-line is ignored
    do_start(10'h001);
    send_beat(rand_beat(), 2'd0);
    send_beat(rand_beat(), 2'd1);
    start = 1'b1;
    line = 10'h3FF;
    tick();
    start = 1'b0;
    send_beat(rand_beat(), 2'd2);
    send_beat(rand_beat(), 2'd3);
    wait_done(9);
    // reset mid-line after beat 1 is accepted
    do_start(10'h2AA);
    send_beat(rand_beat(), 2'd0);
    send_beat(rand_beat(), 2'd1);
    rst_n = 1'b0;
    void'(sb.pop_back());
    vld = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rdy", rdy, 0);
    end
    tick();
    vld = 1'b0;
    do_start(10'h0AB);
    for (int b = 0; b < 4; b++) send_beat(rand_beat(), 2'(b));
    wait_done(9);
    check("done_total", done_cnt, 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
